commit_aggregator: RTL and testbench
====================================

# commit_aggregator

Collects per-TPU commit pulses for every thread the MPU issues and emits one aggregated commit per issue number once all participating TPUs have committed. It sits between the TPU array, which produces the per-TPU commits, and the MPU issue/commit logic, which consumes the aggregated commit. It holds a small table of `pkg_top::commit_agg_t` entries, one per in-flight issue.

## Interface
Parameters:
- NUM_TPU, default 4 (pkg_top::NUM_TPU): number of TPUs; width of enable and commit vectors.
- BUFF_SIZE, default 4 (pkg_top::BYPASS_BUFF_SIZE): number of table entries.
- ISSUE_W, default 5 ($bits(mpu_issue_no_t)): issue-number width.

Ports:
- clock, in, 1: single clock; all state updates on its rising edge.
- reset, in, 1: synchronous, active-low.
- I_Req_Issue, in, 1: MPU issues a thread this cycle.
- I_Issue_No, in, ISSUE_W: issue number of the new thread.
- I_En_TPU, in, NUM_TPU: TPUs participating in the new thread.
- I_Commit, in, NUM_TPU: per-TPU commit pulse.
- I_Commit_No, in, NUM_TPU*ISSUE_W: per-TPU issue number being committed; slice t belongs to TPU t.
- O_Commit, out, 1: one-cycle aggregated commit pulse.
- O_Commit_No, out, ISSUE_W: issue number of the aggregated commit.
- O_Full, out, 1: all entries valid; MPU must not issue.
- O_Empty, out, 1: no valid entries.
- O_Error, out, 1: sticky flag for overflow or an unmatched commit.

## Operation
**Table.** BUFF_SIZE registered entries, each holding {v, issue_no, en_tpu, commit}.

**Allocate.**
- When I_Req_Issue=1 and O_Full=0, write the lowest-index entry with v=0: v=1, issue_no=I_Issue_No, en_tpu=I_En_TPU, commit=0.
- When I_Req_Issue=1 and O_Full=1, drop the issue, leave the table unchanged and set O_Error.

**Commit match.**
- For each TPU t with I_Commit[t]=1, find the valid entries where issue_no equals slice t and en_tpu[t]=1.
- Set commit[t] in the lowest-index match.
- If nothing matches, ignore the commit and set O_Error.
- Several TPUs may commit in the same cycle, to the same entry or to different entries; all of them are applied.
- A repeated commit to a bit that is already set has no effect and is not an error.

**Complete.** An entry is complete when v=1 and (commit | ~en_tpu) is all ones. An entry allocated with en_tpu=0 is therefore complete immediately.

**Retire.**
- Each cycle, select the lowest-index complete entry, if any.
- On the next edge: O_Commit←1, O_Commit_No←its issue_no, and clear that entry's v.
- If nothing is complete: O_Commit←0 and O_Commit_No holds its value.
- At most one retire per cycle. Other complete entries wait.
- Retire order is by entry index, not issue order.

**Status.** O_Full = &v and O_Empty = ~|v, both decoded from the registered v bits. O_Error clears only on reset.

## Timing
**Reset.** While reset=0 at an edge: all v←0, all entry fields←0, O_Commit←0, O_Commit_No←0, O_Error←0. After the edge, O_Full=0 and O_Empty=1. Reset mid-operation discards all in-flight entries without emitting commits.

**Latencies.**
- Issue sampled at edge k: the entry is valid after edge k, and O_Full/O_Empty reflect it in cycle k+1.
- Final commit sampled at edge k: the commit bit is set after edge k, and O_Commit is high for exactly the one cycle after edge k+1. That is 2 cycles from the last commit to the aggregated commit.

**Simultaneous events.**
- Retire and allocate in the same cycle: the freed slot is not visible until the next cycle. O_Full uses the pre-edge v, and the allocation goes to a different free entry or is dropped if full.
- A commit in the same cycle as the allocation of its issue number: no match, so it is ignored and O_Error is set.
- A commit and a retire of different entries in the same cycle: both take effect.

**No backpressure.** There is no backpressure on O_Commit; the consumer must accept the pulse.

## Test plan
- Reset, then issue #3 with en=4'b0101; commit TPU0 #3 at edge 2 and TPU2 #3 at edge 4 → O_Commit=1 with O_Commit_No=3 for exactly one cycle after edge 5; O_Empty=1 afterwards.
- Issue #1, #2, #3, #4 with en=4'b1111 on consecutive cycles → O_Full=1. A fifth issue #5 → dropped, O_Error=1. Complete #2 → one commit of 2, then O_Full=0.
- Issue #7 and #8 with en=4'b0011; commit both TPUs to both numbers in the same cycle → commits #7 and #8 on consecutive cycles (lower entry index first).
- Commit TPU1 with #9 while #9 is not in flight → table unchanged, O_Error=1, no O_Commit.
- Issue #6 with en=4'b0000 → O_Commit with O_Commit_No=6 in the cycle after the next edge following allocation.
- Fill 3 entries, commit 2 TPUs, assert reset=0 for one edge → O_Empty=1, O_Commit=0; later commits to the old numbers set O_Error.

Source files
------------

// File: rtl/commit_aggregator.sv
// Aggregates per-TPU commit pulses into a single commit per issue number.
// A small table tracks in-flight issues; complete entries retire lowest index first.
module commit_aggregator #(
  parameter int NUM_TPU   = 4,
  parameter int BUFF_SIZE = 4,
  parameter int ISSUE_W   = 5
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       I_Req_Issue,
  input  logic [ISSUE_W-1:0]         I_Issue_No,
  input  logic [NUM_TPU-1:0]         I_En_TPU,
  input  logic [NUM_TPU-1:0]         I_Commit,
  input  logic [NUM_TPU*ISSUE_W-1:0] I_Commit_No,
  output logic                       O_Commit,
  output logic [ISSUE_W-1:0]         O_Commit_No,
  output logic                       O_Full,
  output logic                       O_Empty,
  output logic                       O_Error
);

  localparam int IDX_W = (BUFF_SIZE > 1) ? $clog2(BUFF_SIZE) : 1;

  logic [BUFF_SIZE-1:0] v_q, v_d;
  logic [ISSUE_W-1:0]   no_q [BUFF_SIZE];
  logic [ISSUE_W-1:0]   no_d [BUFF_SIZE];
  logic [NUM_TPU-1:0]   en_q [BUFF_SIZE];
  logic [NUM_TPU-1:0]   en_d [BUFF_SIZE];
  logic [NUM_TPU-1:0]   cm_q [BUFF_SIZE];
  logic [NUM_TPU-1:0]   cm_d [BUFF_SIZE];
  logic                 commit_q, commit_d;
  logic [ISSUE_W-1:0]   commit_no_q, commit_no_d;
  logic                 err_q, err_d;

  logic [BUFF_SIZE-1:0] complete;
  logic                 ret_hit, free_hit;
  logic [IDX_W-1:0]     ret_idx, free_idx;
  logic [NUM_TPU-1:0]   match_hit;
  logic [IDX_W-1:0]     match_idx [NUM_TPU];

  // Descending scans so the last assignment wins, giving lowest-index priority.
  always_comb begin
    complete = '0;
    ret_hit  = 1'b0;
    ret_idx  = '0;
    free_hit = 1'b0;
    free_idx = '0;
    for (int i = BUFF_SIZE - 1; i >= 0; i--) begin
      complete[i] = v_q[i] & (&(cm_q[i] | ~en_q[i]));
      if (complete[i]) begin
        ret_hit = 1'b1;
        ret_idx = IDX_W'(i);
      end
      if (!v_q[i]) begin
        free_hit = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    for (int t = 0; t < NUM_TPU; t++) begin
      match_hit[t] = 1'b0;
      match_idx[t] = '0;
      for (int i = BUFF_SIZE - 1; i >= 0; i--) begin
        if (v_q[i] && en_q[i][t] &&
            (no_q[i] == I_Commit_No[t*ISSUE_W +: ISSUE_W])) begin
          match_hit[t] = 1'b1;
          match_idx[t] = IDX_W'(i);
        end
      end
    end
  end

  always_comb begin
    v_d         = v_q;
    no_d        = no_q;
    en_d        = en_q;
    cm_d        = cm_q;
    err_d       = err_q;
    commit_d    = ret_hit;
    commit_no_d = commit_no_q;

    if (ret_hit) begin
      commit_no_d    = no_q[ret_idx];
      v_d[ret_idx]   = 1'b0;
    end

    // The retiring slot is still valid here, so allocation never lands on it.
    if (I_Req_Issue) begin
      if (!free_hit) begin
        err_d = 1'b1;
      end else begin
        v_d[free_idx]  = 1'b1;
        no_d[free_idx] = I_Issue_No;
        en_d[free_idx] = I_En_TPU;
        cm_d[free_idx] = '0;
      end
    end

    for (int t = 0; t < NUM_TPU; t++) begin
      if (I_Commit[t]) begin
        if (match_hit[t]) cm_d[match_idx[t]][t] = 1'b1;
        else              err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      v_q         <= '0;
      commit_q    <= 1'b0;
      commit_no_q <= '0;
      err_q       <= 1'b0;
      for (int i = 0; i < BUFF_SIZE; i++) begin
        no_q[i] <= '0;
        en_q[i] <= '0;
        cm_q[i] <= '0;
      end
    end else begin
      v_q         <= v_d;
      commit_q    <= commit_d;
      commit_no_q <= commit_no_d;
      err_q       <= err_d;
      for (int i = 0; i < BUFF_SIZE; i++) begin
        no_q[i] <= no_d[i];
        en_q[i] <= en_d[i];
        cm_q[i] <= cm_d[i];
      end
    end
  end

  assign O_Commit    = commit_q;
  assign O_Commit_No = commit_no_q;
  assign O_Full      = &v_q;
  assign O_Empty     = ~|v_q;
  assign O_Error     = err_q;

endmodule

// File: tb/tb_commit_aggregator.sv
// Bench for commit_aggregator: directed scenarios plus random traffic
// checked against a table-level reference model.
module tb_commit_aggregator;
  localparam int NT = 4;
  localparam int NB = 4;
  localparam int IW = 5;

  logic            clock = 1'b0;
  logic            reset;
  logic            I_Req_Issue;
  logic [IW-1:0]   I_Issue_No;
  logic [NT-1:0]   I_En_TPU;
  logic [NT-1:0]   I_Commit;
  logic [NT*IW-1:0] I_Commit_No;
  logic            O_Commit;
  logic [IW-1:0]   O_Commit_No;
  logic            O_Full, O_Empty, O_Error;

  int tests_run = 0;
  int tests_failed = 0;

  // reference model state
  bit            m_v  [NB];
  logic [IW-1:0] m_no [NB];
  logic [NT-1:0] m_en [NB];
  logic [NT-1:0] m_cm [NB];
  logic          m_oc;
  logic [IW-1:0] m_ono;
  logic          m_err;

  commit_aggregator #(.NUM_TPU(NT), .BUFF_SIZE(NB), .ISSUE_W(IW)) dut (
    .clock(clock), .reset(reset),
    .I_Req_Issue(I_Req_Issue), .I_Issue_No(I_Issue_No), .I_En_TPU(I_En_TPU),
    .I_Commit(I_Commit), .I_Commit_No(I_Commit_No),
    .O_Commit(O_Commit), .O_Commit_No(O_Commit_No),
    .O_Full(O_Full), .O_Empty(O_Empty), .O_Error(O_Error)
  );

  always #5 clock = ~clock;

  task automatic model_step();
    bit            n_v  [NB];
    logic [NT-1:0] n_cm [NB];
    int ret, fr, hit;
    bit full;
    if (!reset) begin
      for (int i = 0; i < NB; i++) begin
        m_v[i] = 0; m_no[i] = '0; m_en[i] = '0; m_cm[i] = '0;
      end
      m_oc = 0; m_ono = '0; m_err = 0;
      return;
    end
    n_v = m_v; n_cm = m_cm;
    ret = -1; fr = -1; full = 1;
    for (int i = 0; i < NB; i++) begin
      if (ret < 0 && m_v[i] && ((m_cm[i] | ~m_en[i]) == {NT{1'b1}})) ret = i;
      if (!m_v[i]) begin
        full = 0;
        if (fr < 0) fr = i;
      end
    end
    for (int t = 0; t < NT; t++) begin
      if (I_Commit[t]) begin
        hit = -1;
        for (int i = 0; i < NB; i++)
          if (hit < 0 && m_v[i] && m_en[i][t] && m_no[i] == I_Commit_No[t*IW +: IW]) hit = i;
        if (hit < 0) m_err = 1;
        else n_cm[hit][t] = 1'b1;
      end
    end
    if (I_Req_Issue) begin
      if (full) m_err = 1;
      else begin
        n_v[fr] = 1; m_no[fr] = I_Issue_No; m_en[fr] = I_En_TPU; n_cm[fr] = '0;
      end
    end
    if (ret >= 0) begin
      m_oc = 1; m_ono = m_no[ret]; n_v[ret] = 0;
    end else m_oc = 0;
    m_v = n_v; m_cm = n_cm;
  endtask

  task automatic cyc();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    I_Req_Issue = 0; I_Issue_No = '0; I_En_TPU = '0; I_Commit = '0; I_Commit_No = '0;
  endtask

  task automatic issue(input logic [IW-1:0] no, input logic [NT-1:0] en);
    I_Req_Issue = 1; I_Issue_No = no; I_En_TPU = en;
  endtask

  task automatic commit(input int t, input logic [IW-1:0] no);
    I_Commit[t] = 1'b1; I_Commit_No[t*IW +: IW] = no;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 0; cyc(); cyc();
    reset = 1;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++; if (O_Empty !== 1'b1) begin tests_failed++; $display("FAIL reset_empty got %b want 1", O_Empty); end
    tests_run++; if (O_Full !== 1'b0) begin tests_failed++; $display("FAIL reset_full got %b want 0", O_Full); end
    tests_run++; if (O_Commit !== 1'b0) begin tests_failed++; $display("FAIL reset_commit got %b want 0", O_Commit); end
    tests_run++; if (O_Commit_No !== 5'd0) begin tests_failed++; $display("FAIL reset_commit_no got %0d want 0", O_Commit_No); end
    tests_run++; if (O_Error !== 1'b0) begin tests_failed++; $display("FAIL reset_error got %b want 0", O_Error); end
  endtask

  task automatic test_basic();
    do_reset();
    issue(5'd3, 4'b0101); cyc(); idle_inputs();
    tests_run++; if (O_Empty !== 1'b0) begin tests_failed++; $display("FAIL basic_not_empty got %b want 0", O_Empty); end
    commit(0, 5'd3); cyc(); idle_inputs();
    cyc();
    commit(2, 5'd3); cyc(); idle_inputs();
    tests_run++; if (O_Commit !== 1'b0) begin tests_failed++; $display("FAIL basic_early got %b want 0", O_Commit); end
    cyc();
    tests_run++; if (O_Commit !== 1'b1 || O_Commit_No !== 5'd3) begin tests_failed++; $display("FAIL basic_commit got %b/%0d want 1/3", O_Commit, O_Commit_No); end
    cyc();
    tests_run++; if (O_Commit !== 1'b0 || O_Empty !== 1'b1) begin tests_failed++; $display("FAIL basic_after got commit %b empty %b want 0/1", O_Commit, O_Empty); end
    tests_run++; if (O_Error !== 1'b0) begin tests_failed++; $display("FAIL basic_error got %b want 0", O_Error); end
  endtask

  task automatic test_full();
    do_reset();
    for (int n = 1; n <= 4; n++) begin
      issue(IW'(n), 4'b1111); cyc();
    end
    idle_inputs();
    tests_run++; if (O_Full !== 1'b1 || O_Error !== 1'b0) begin tests_failed++; $display("FAIL full_set got full %b err %b want 1/0", O_Full, O_Error); end
    issue(5'd5, 4'b1111); cyc(); idle_inputs();
    tests_run++; if (O_Error !== 1'b1 || O_Full !== 1'b1) begin tests_failed++; $display("FAIL full_drop got err %b full %b want 1/1", O_Error, O_Full); end
    for (int t = 0; t < NT; t++) commit(t, 5'd2);
    cyc(); idle_inputs();
    tests_run++; if (O_Commit !== 1'b0) begin tests_failed++; $display("FAIL full_early got %b want 0", O_Commit); end
    cyc();
    tests_run++; if (O_Commit !== 1'b1 || O_Commit_No !== 5'd2 || O_Full !== 1'b0) begin tests_failed++; $display("FAIL full_retire got %b/%0d full %b want 1/2/0", O_Commit, O_Commit_No, O_Full); end
    cyc();
    tests_run++; if (O_Commit !== 1'b0) begin tests_failed++; $display("FAIL full_single got %b want 0", O_Commit); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    issue(5'd7, 4'b0011); cyc();
    issue(5'd8, 4'b0011); cyc(); idle_inputs();
    commit(0, 5'd7); commit(1, 5'd8); cyc(); idle_inputs();
    commit(0, 5'd8); commit(1, 5'd7); cyc(); idle_inputs();
    tests_run++; if (O_Commit !== 1'b0) begin tests_failed++; $display("FAIL b2b_early got %b want 0", O_Commit); end
    cyc();
    tests_run++; if (O_Commit !== 1'b1 || O_Commit_No !== 5'd7) begin tests_failed++; $display("FAIL b2b_first got %b/%0d want 1/7", O_Commit, O_Commit_No); end
    cyc();
    tests_run++; if (O_Commit !== 1'b1 || O_Commit_No !== 5'd8) begin tests_failed++; $display("FAIL b2b_second got %b/%0d want 1/8", O_Commit, O_Commit_No); end
    cyc();
    tests_run++; if (O_Commit !== 1'b0 || O_Empty !== 1'b1 || O_Error !== 1'b0) begin tests_failed++; $display("FAIL b2b_end got c%b e%b err%b want 0/1/0", O_Commit, O_Empty, O_Error); end
  endtask

  task automatic test_unmatched();
    do_reset();
    commit(1, 5'd9); cyc(); idle_inputs();
    tests_run++; if (O_Error !== 1'b1 || O_Empty !== 1'b1) begin tests_failed++; $display("FAIL unmatched got err %b empty %b want 1/1", O_Error, O_Empty); end
    cyc();
    tests_run++; if (O_Commit !== 1'b0 || O_Error !== 1'b1) begin tests_failed++; $display("FAIL unmatched_sticky got c%b err%b want 0/1", O_Commit, O_Error); end
  endtask

  task automatic test_zero_en();
    do_reset();
    issue(5'd6, 4'b0000); cyc(); idle_inputs();
    tests_run++; if (O_Commit !== 1'b0 || O_Empty !== 1'b0) begin tests_failed++; $display("FAIL zero_alloc got c%b e%b want 0/0", O_Commit, O_Empty); end
    cyc();
    tests_run++; if (O_Commit !== 1'b1 || O_Commit_No !== 5'd6 || O_Empty !== 1'b1) begin tests_failed++; $display("FAIL zero_retire got %b/%0d e%b want 1/6/1", O_Commit, O_Commit_No, O_Empty); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    issue(5'd10, 4'b1111); cyc();
    issue(5'd11, 4'b1111); cyc();
    issue(5'd12, 4'b1111); cyc(); idle_inputs();
    commit(0, 5'd10); commit(1, 5'd11); cyc(); idle_inputs();
    reset = 0; cyc(); reset = 1;
    tests_run++; if (O_Empty !== 1'b1 || O_Commit !== 1'b0 || O_Error !== 1'b0) begin tests_failed++; $display("FAIL midreset got e%b c%b err%b want 1/0/0", O_Empty, O_Commit, O_Error); end
    commit(0, 5'd10); commit(2, 5'd12); cyc(); idle_inputs();
    tests_run++; if (O_Error !== 1'b1 || O_Commit !== 1'b0) begin tests_failed++; $display("FAIL midreset_old got err%b c%b want 1/0", O_Error, O_Commit); end
  endtask

  task automatic test_random();
    int j;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      idle_inputs();
      reset = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 2) == 0) issue(IW'($urandom_range(0, 7)), NT'($urandom_range(0, 15)));
      for (int t = 0; t < NT; t++) begin
        if ($urandom_range(0, 1) == 1) begin
          j = $urandom_range(0, NB - 1);
          if (m_v[j] && $urandom_range(0, 3) != 0) commit(t, m_no[j]);
          else commit(t, IW'($urandom_range(0, 7)));
        end
      end
      cyc();
      tests_run++;
      if (O_Commit !== m_oc || O_Commit_No !== m_ono || O_Error !== m_err ||
          O_Full !== (m_v[0] & m_v[1] & m_v[2] & m_v[3]) ||
          O_Empty !== !(m_v[0] | m_v[1] | m_v[2] | m_v[3])) begin
        tests_failed++;
        $display("FAIL random cyc %0d got c%b no%0d err%b f%b e%b want c%b no%0d err%b f%b e%b",
                 c, O_Commit, O_Commit_No, O_Error, O_Full, O_Empty, m_oc, m_ono, m_err,
                 (m_v[0] & m_v[1] & m_v[2] & m_v[3]), !(m_v[0] | m_v[1] | m_v[2] | m_v[3]));
      end
    end
    reset = 1; idle_inputs();
  endtask

  initial begin
    reset = 0;
    idle_inputs();
    #1;
    test_reset();
    test_basic();
    test_full();
    test_back_to_back();
    test_unmatched();
    test_zero_en();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
